serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- Built around a single-bit full-subtractor cell, the borrow-propagating counterpart of the team's full-adder cell.
- Used where area matters more than latency; a start/done handshake lets a controller launch operations and collect results.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request new operation; sampled only when ready=1.
- a  input  WIDTH  minuend, captured on the accepted start edge.
- b  input  WIDTH  subtrahend, captured on the accepted start edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse, results valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned.
- overflow  output  1  two's-complement overflow of a - b.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, ready=1, busy=0, done=0, diff=0, borrow_out=0, overflow=0, internal shift registers, borrow and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge E0, load a and b into shift registers, clear borrow and counter, save sign bits a[WIDTH-1] and b[WIDTH-1], go to RUN. Otherwise stay in IDLE.
- RUN: at each edge, feed bit0 of each shift register plus the borrow register into the cell.
  - d = x ^ y ^ bin
  - bout = (~x & y) | (~x & bin) | (y & bin)
  - Shift d into the result register from the MSB side, register bout, shift operands right, increment counter.
  - After the WIDTH-th RUN edge (edge E_WIDTH), go to DONE.
- DONE (exactly one cycle): done=1; diff, borrow_out and overflow are valid. Next edge goes to IDLE.
- Latency: done is high in the cycle following E_WIDTH, i.e. WIDTH cycles after the start edge. Throughput is one operation per WIDTH+2 cycles.
- Result holding: diff, borrow_out and overflow hold their values from DONE until the next accepted start. At that point they keep their old values until overwritten at the new DONE; the result register shifts internally and a separate output register updates only on entry to DONE.
- Overflow rule: overflow = (a_msb != b_msb) & (diff_msb != a_msb).
- start while busy or in DONE: ignored, with no effect on the operation in flight.
- Operands a and b may change freely after the accepted start edge.
- rst asserted mid-operation: abort on that edge; all outputs take their reset values. done must not pulse for the aborted operation.
- rst and start asserted on the same edge: rst wins and start is dropped.
- WIDTH=1: a single RUN cycle; overflow is defined by the same rule.
- Arithmetic: the borrow register is 1 bit, the counter is CNT_W bits, and no internal value is wider than WIDTH.

Decomposition:
- Shared package serial_arith_pkg:
  - state enum sub_state_t {IDLE, RUN, DONE} (2-bit logic).
  - localparam DEFAULT_WIDTH = 8.
- Sub-module full_subtractor_cell (inputs x, y, bin; outputs d, bout):
  - pure dataflow assigns, one instance.
  - Kept separate so it can be unit-tested exhaustively (8 input combinations) and reused by a future ripple subtractor.

Test Plan (WIDTH=8):
- Reset, then start with a=0x05, b=0x03 -> done exactly 8 cycles after the start edge; diff=0x02, borrow_out=0, overflow=0; ready returns high the following cycle.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- Start a=0x10, b=0x01 (result 0x0F). While busy, pulse start with a=0xFF, b=0x00 and change the a/b inputs -> the second start is ignored, result is 0x0F, and exactly one done pulse occurs.
- Start a=0x55, b=0x22 and assert rst at cycle 4 -> no done pulse, all outputs 0, ready=1. Then a=0x00, b=0x00 -> diff=0x00, borrow_out=0, overflow=0.
- Back-to-back operations: start again in the first ready cycle after done. Previous results must stay stable until the new done, and 200 random operand pairs must match a - b against a reference model.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, with start/done handshake.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_out_q, borrow_out_d;
   logic             overflow_q, overflow_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cell_d;
   logic             cell_bout;
   logic [WIDTH-1:0] res_shift;

   full_subtractor_cell u_cell (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Shift-based insert keeps WIDTH=1 legal (no zero-width slice).
   assign res_shift = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

   always_comb begin
      state_d      = state_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      res_d        = res_q;
      borrow_d     = borrow_q;
      cnt_d        = cnt_q;
      a_msb_d      = a_msb_q;
      b_msb_d      = b_msb_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      overflow_d   = overflow_q;
      ready_d      = ready_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
               state_d  = RUN;
               ready_d  = 1'b0;
               busy_d   = 1'b1;
            end
         end
         RUN: begin
            res_d    = res_shift;
            borrow_d = cell_bout;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d      = DONE;
               busy_d       = 1'b0;
               done_d       = 1'b1;
               diff_d       = res_shift;
               borrow_out_d = cell_bout;
               overflow_d   = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         res_q        <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         res_q        <= res_d;
         borrow_q     <= borrow_d;
         cnt_q        <= cnt_d;
         a_msb_q      <= a_msb_d;
         b_msb_q      <= b_msb_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         overflow_q   <= overflow_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ready      = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   // Reference: plain integer arithmetic, signed and unsigned views.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] d, output logic bo, output logic ov);
      int ud;
      int sx;
      int sy;
      int sd;
      ud = int'(x) - int'(y);
      sx = $signed(x);
      sy = $signed(y);
      sd = sx - sy;
      d  = ud[W-1:0];
      bo = (ud < 0);
      ov = (sd > 127) || (sd < -128);
   endfunction

   // Launches one operation; returns done latency (0 on timeout), whether the
   // held outputs stayed stable until done, and ready when start was raised.
   task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output int lat, output bit stable, output logic rdy);
      logic [W-1:0] pd;
      logic         pb;
      logic         po;
      @(negedge clk);
      rdy   = ready;
      start = 1'b1;
      a     = xa;
      b     = xb;
      pd    = diff;
      pb    = borrow_out;
      po    = overflow;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      a      = W'($urandom);
      b      = W'($urandom);
      lat    = 0;
      stable = 1'b1;
      if (diff !== pd || borrow_out !== pb || overflow !== po) stable = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            break;
         end
         if (diff !== pd || borrow_out !== pb || overflow !== po) stable = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", diff); end
      checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
   endtask

   task automatic test_basic();
      logic [W-1:0] ta [4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
      logic [W-1:0] tb [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
      logic [W-1:0] td [4] = '{8'h02, 8'hFE, 8'h7F, 8'h80};
      logic         tbo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic         tov [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int lat;
      bit stable;
      logic rdy;
      for (int i = 0; i < 4; i++) begin
         launch(ta[i], tb[i], lat, stable, rdy);
         $display("basic op a=%h b=%h -> diff=%h borrow=%b ovf=%b latency=%0d",
                  ta[i], tb[i], diff, borrow_out, overflow, lat);
         checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 8", i, lat); end
         checks++; if (diff !== td[i]) begin errors++; $display("FAIL basic_diff[%0d] got %h want %h", i, diff, td[i]); end
         checks++; if (borrow_out !== tbo[i]) begin errors++; $display("FAIL basic_borrow[%0d] got %b want %b", i, borrow_out, tbo[i]); end
         checks++; if (overflow !== tov[i]) begin errors++; $display("FAIL basic_overflow[%0d] got %b want %b", i, overflow, tov[i]); end
         @(negedge clk);
         checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_after_done[%0d] ready=%b done=%b want ready=1 done=0", i, ready, done); end
         checks++; if (diff !== td[i]) begin errors++; $display("FAIL basic_hold[%0d] got %h want %h", i, diff, td[i]); end
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      int lat = 0;
      logic [W-1:0] rd = '0;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h01;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL ignore_busy busy=%b ready=%b want 1/0", busy, ready); end
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (c == 3) begin
            start = 1'b1;
            a     = 8'hFF;
            b     = 8'h00;
         end else if (c == 4) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
         end
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin
               lat = c;
               rd  = diff;
            end
         end
      end
      $display("ignore op a=10 b=01 -> diff=%h done_pulses=%0d latency=%0d", rd, ndone, lat);
      checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
      checks++; if (lat != 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", lat); end
      checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL ignore_diff got %h want 0f", rd); end
      checks++; if (borrow_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL ignore_flags got b=%b o=%b want 0/0", borrow_out, overflow); end
   endtask

   task automatic test_rst_abort();
      int ndone = 0;
      int lat;
      bit stable;
      logic rdy;
      @(negedge clk);
      start = 1'b1;
      a     = 8'h55;
      b     = 8'h22;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 3) rst = 1'b1;
         else if (c == 4) rst = 1'b0;
         if (done === 1'b1) ndone++;
      end
      $display("abort op a=55 b=22 rst@4 -> done_pulses=%0d diff=%h ready=%b", ndone, diff, ready);
      checks++; if (ndone != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", ndone); end
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_handshake ready=%b busy=%b want 1/0", ready, busy); end
      checks++; if (diff !== 8'h00) begin errors++; $display("FAIL abort_diff got %h want 00", diff); end
      checks++; if (borrow_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL abort_flags b=%b o=%b want 0/0", borrow_out, overflow); end

      // rst and start on the same edge: start must be dropped.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'h09;
      b     = 8'h03;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      ndone = 0;
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_start ready=%b busy=%b want 1/0", ready, busy); end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      $display("rst+start same edge -> done_pulses=%0d", ndone);
      checks++; if (ndone != 0) begin errors++; $display("FAIL rst_start_done got %0d want 0", ndone); end

      launch(8'h00, 8'h00, lat, stable, rdy);
      $display("zero op a=00 b=00 -> diff=%h borrow=%b ovf=%b latency=%0d", diff, borrow_out, overflow, lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL zero_latency got %0d want 8", lat); end
      checks++; if (diff !== 8'h00 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
         errors++; $display("FAIL zero_result got %h/%b/%b want 00/0/0", diff, borrow_out, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] xa;
      logic [W-1:0] xb;
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      int lat;
      bit stable;
      logic rdy;
      for (int i = 0; i < 200; i++) begin
         xa = W'($urandom);
         xb = W'($urandom);
         if (i % 17 == 0) xa = 8'h80;
         if (i % 23 == 0) xb = 8'hFF;
         model(xa, xb, ed, eb, eo);
         launch(xa, xb, lat, stable, rdy);
         $display("b2b op %0d a=%h b=%h -> diff=%h borrow=%b ovf=%b expect %h/%b/%b",
                  i, xa, xb, diff, borrow_out, overflow, ed, eb, eo);
         checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, rdy); end
         checks++; if (lat != 8) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 8", i, lat); end
         checks++; if (!stable) begin errors++; $display("FAIL b2b_hold[%0d] outputs changed before done got 0 want 1", i); end
         checks++; if (diff !== ed) begin errors++; $display("FAIL b2b_diff[%0d] got %h want %h", i, diff, ed); end
         checks++; if (borrow_out !== eb) begin errors++; $display("FAIL b2b_borrow[%0d] got %b want %b", i, borrow_out, eb); end
         checks++; if (overflow !== eo) begin errors++; $display("FAIL b2b_overflow[%0d] got %b want %b", i, overflow, eo); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_rst_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
